// File: rtl/registor_writeback.sv
// registor_writeback: write side of the phase-based register file.
// Owns eip/ebp/esp and runs one instruction through an 8-phase frame.
// It also drives the clock_3/5/7 phase strobes and commits up to three
// latched write codes at the edges that end phases 4, 6 and 7.
// Optional feature macro: REGISTOR_STACK_GUARD_EN. When it is defined,
// esp push/pop past STACK_LIMIT or past the ends of the address space is
// suppressed, and the sticky stack_fault output is present.
//
// Handshake: start is a level request. It is accepted on a rising edge
// when the block is idle, or when it is in phase 7. In both cases the
// write selects and instr_len are latched on that same edge. A start seen
// in phases 0..6 is ignored. busy reflects the FSM state (IDLE=0, RUN=1).
module registor_writeback #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] EIP_RESET   = 32'h0000_0000,
    parameter logic [WIDTH-1:0] ESP_RESET   = 32'h0000_0100,
    parameter int unsigned      STACK_STEP  = 4,
    parameter logic [WIDTH-1:0] STACK_LIMIT = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       write_sel_1,
    input  logic [3:0]       write_sel_2,
    input  logic [3:0]       write_sel_3,
    input  logic [3:0]       instr_len,
    input  logic [WIDTH-1:0] registor_input,
    output logic [WIDTH-1:0] eip,
    output logic [WIDTH-1:0] ebp,
    output logic [WIDTH-1:0] esp,
    output logic [2:0]       phase,
    output logic             clock_3,
    output logic             clock_5,
    output logic             clock_7,
    output logic             busy,
    output logic             done,
`ifdef REGISTOR_STACK_GUARD_EN
    output logic             stack_fault,
`endif
    output logic             illegal_sel
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);
    // Largest esp that can still be popped without wrapping past all-ones.
    localparam logic [WIDTH-1:0] POP_MAX = {WIDTH{1'b1}} - STEP;

    logic [0:0]       state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       sel1_q, sel1_d, sel2_q, sel2_d, sel3_q, sel3_d;
    logic [3:0]       len_q, len_d;
    logic [WIDTH-1:0] eip_q, eip_d, ebp_q, ebp_d, esp_q, esp_d;
    logic             c3_q, c3_d, c5_q, c5_d, c7_q, c7_d;
    logic             ill_q, ill_d;
    logic             accept;
    logic [WIDTH-1:0] len_ext;
`ifdef REGISTOR_STACK_GUARD_EN
    logic             fault_q, fault_d;
`endif

    assign len_ext = {{(WIDTH-4){1'b0}}, len_q};

    // Next-state logic: frame sequencing, slot commits and strobe decode.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sel1_d  = sel1_q;
        sel2_d  = sel2_q;
        sel3_d  = sel3_q;
        len_d   = len_q;
        eip_d   = eip_q;
        ebp_d   = ebp_q;
        esp_d   = esp_q;
        ill_d   = ill_q;
`ifdef REGISTOR_STACK_GUARD_EN
        fault_d = fault_q;
`endif
        accept  = start && ((state_q == S_IDLE) || (phase_q == 3'd7));

        if (state_q == S_RUN) begin
            // Phase 7 + 1 wraps to 0, which is also the idle phase value.
            phase_d = phase_q + 3'd1;
            if (phase_q == 3'd7) begin
                state_d = S_IDLE;
            end
            case (phase_q)
                3'd4: begin
                    case (sel1_q)
                        4'd0: ;
                        4'd1: begin
`ifdef REGISTOR_STACK_GUARD_EN
                            if ((esp_q < STEP) || ((esp_q - STEP) < STACK_LIMIT)) begin
                                fault_d = 1'b1;
                            end else begin
                                esp_d = esp_q - STEP;
                            end
`else
                            esp_d = esp_q - STEP;
`endif
                        end
                        4'd2: begin
`ifdef REGISTOR_STACK_GUARD_EN
                            if (esp_q > POP_MAX) begin
                                fault_d = 1'b1;
                            end else begin
                                esp_d = esp_q + STEP;
                            end
`else
                            esp_d = esp_q + STEP;
`endif
                        end
                        4'd3: esp_d = registor_input;
                        4'd4: ebp_d = registor_input;
                        default: ill_d = 1'b1;
                    endcase
                end
                3'd6: begin
                    // Codes 3/4 see the values already committed by slot 1.
                    case (sel2_q)
                        4'd0: ;
                        4'd1: ebp_d = registor_input;
                        4'd2: esp_d = registor_input;
                        4'd3: ebp_d = esp_q;
                        4'd4: esp_d = ebp_q;
                        default: ill_d = 1'b1;
                    endcase
                end
                3'd7: begin
                    case (sel3_q)
                        4'd0: eip_d = eip_q + len_ext;
                        4'd1: ;
                        4'd2: eip_d = registor_input;
                        default: begin
                            eip_d = eip_q + len_ext;
                            ill_d = 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        // Latching after the phase-7 commit lets back-to-back frames chain.
        if (accept) begin
            state_d = S_RUN;
            phase_d = 3'd0;
            sel1_d  = write_sel_1;
            sel2_d  = write_sel_2;
            sel3_d  = write_sel_3;
            len_d   = instr_len;
        end

        // Strobes are decoded from the next phase so they align with it.
        c3_d = (state_d == S_RUN) && (phase_d == 3'd3);
        c5_d = (state_d == S_RUN) && (phase_d == 3'd5);
        c7_d = (state_d == S_RUN) && (phase_d == 3'd7);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 3'd0;
            sel1_q  <= 4'd0;
            sel2_q  <= 4'd0;
            sel3_q  <= 4'd0;
            len_q   <= 4'd0;
            eip_q   <= EIP_RESET;
            ebp_q   <= ESP_RESET;
            esp_q   <= ESP_RESET;
            c3_q    <= 1'b0;
            c5_q    <= 1'b0;
            c7_q    <= 1'b0;
            ill_q   <= 1'b0;
`ifdef REGISTOR_STACK_GUARD_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
            sel3_q  <= sel3_d;
            len_q   <= len_d;
            eip_q   <= eip_d;
            ebp_q   <= ebp_d;
            esp_q   <= esp_d;
            c3_q    <= c3_d;
            c5_q    <= c5_d;
            c7_q    <= c7_d;
            ill_q   <= ill_d;
`ifdef REGISTOR_STACK_GUARD_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign eip         = eip_q;
    assign ebp         = ebp_q;
    assign esp         = esp_q;
    assign phase       = phase_q;
    assign busy        = (state_q == S_RUN);
    assign clock_3     = c3_q;
    assign clock_5     = c5_q;
    assign clock_7     = c7_q;
    assign done        = c7_q;
    assign illegal_sel = ill_q;
`ifdef REGISTOR_STACK_GUARD_EN
    assign stack_fault = fault_q;
`endif

endmodule

// File: tb/tb_registor_writeback.sv
// Self-checking bench for registor_writeback (default build).
// Reference model: architectural registers updated by the per-slot rules,
// which are applied once per frame at the phase where each slot commits.
module tb_registor_writeback;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  write_sel_1, write_sel_2, write_sel_3, instr_len;
  logic [31:0] registor_input;
  logic [31:0] eip, ebp, esp;
  logic [2:0]  phase;
  logic        clock_3, clock_5, clock_7, busy, done, illegal_sel;

  int tests_run;
  int tests_failed;

  logic [31:0] m_eip, m_ebp, m_esp;
  logic        m_ill;

  registor_writeback dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .write_sel_1    (write_sel_1),
    .write_sel_2    (write_sel_2),
    .write_sel_3    (write_sel_3),
    .instr_len      (instr_len),
    .registor_input (registor_input),
    .eip            (eip),
    .ebp            (ebp),
    .esp            (esp),
    .phase          (phase),
    .clock_3        (clock_3),
    .clock_5        (clock_5),
    .clock_7        (clock_7),
    .busy           (busy),
    .done           (done),
    .illegal_sel    (illegal_sel)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // reference model
  task automatic model_reset();
    m_eip = 32'h0000_0000;
    m_ebp = 32'h0000_0100;
    m_esp = 32'h0000_0100;
    m_ill = 1'b0;
  endtask

  task automatic model_slot1(input logic [3:0] code, input logic [31:0] d);
    case (code)
      4'd0: ;
      4'd1: m_esp = m_esp - 32'd4;
      4'd2: m_esp = m_esp + 32'd4;
      4'd3: m_esp = d;
      4'd4: m_ebp = d;
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic model_slot2(input logic [3:0] code, input logic [31:0] d);
    case (code)
      4'd0: ;
      4'd1: m_ebp = d;
      4'd2: m_esp = d;
      4'd3: m_ebp = m_esp;
      4'd4: m_esp = m_ebp;
      default: m_ill = 1'b1;
    endcase
  endtask

  task automatic model_slot3(input logic [3:0] code, input logic [3:0] len, input logic [31:0] d);
    case (code)
      4'd1: ;
      4'd2: m_eip = d;
      4'd0: m_eip = m_eip + {28'd0, len};
      default: begin
        m_eip = m_eip + {28'd0, len};
        m_ill = 1'b1;
      end
    endcase
  endtask

  // driver: one frame. It is entered at a negedge with the DUT idle or in
  // phase 7, and it returns at the phase-7 negedge with start low.
  task automatic run_frame(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                           input logic [3:0] len, input bit fix7, input logic [31:0] val7,
                           input string tag);
    logic [31:0] d;
    logic [3:0]  exp_s;
    start = 1'b1;
    write_sel_1 = s1;
    write_sel_2 = s2;
    write_sel_3 = s3;
    instr_len = len;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      // A start in phases 0..6 must be ignored; changing selects must not leak in.
      start = (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      write_sel_1 = 4'($urandom_range(0, 15));
      write_sel_2 = 4'($urandom_range(0, 15));
      write_sel_3 = 4'($urandom_range(0, 15));
      instr_len = 4'($urandom_range(0, 15));
      exp_s = {k == 3, k == 5, k == 7, k == 7};
      tests_run++;
      if (phase !== 3'(k) || busy !== 1'b1 || {clock_3, clock_5, clock_7, done} !== exp_s) begin
        tests_failed++;
        $display("FAIL %s seq k=%0d: got phase=%0d busy=%b c3/c5/c7/done=%b, want phase=%0d busy=1 %b",
                 tag, k, phase, busy, {clock_3, clock_5, clock_7, done}, k, exp_s);
      end
      tests_run++;
      if (eip !== m_eip || ebp !== m_ebp || esp !== m_esp) begin
        tests_failed++;
        $display("FAIL %s regs k=%0d: got eip=%h ebp=%h esp=%h, want eip=%h ebp=%h esp=%h",
                 tag, k, eip, ebp, esp, m_eip, m_ebp, m_esp);
      end
      tests_run++;
      if (illegal_sel !== m_ill) begin
        tests_failed++;
        $display("FAIL %s illegal k=%0d: got %b, want %b", tag, k, illegal_sel, m_ill);
      end
      d = (fix7 && k == 7) ? val7 : $urandom;
      registor_input = d;
      if (k == 4) model_slot1(s1, d);
      if (k == 6) model_slot2(s2, d);
      if (k == 7) model_slot3(s3, len, d);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      start = 1'b0;
      registor_input = $urandom;
      tests_run++;
      if (busy !== 1'b0 || phase !== 3'd0 || {clock_3, clock_5, clock_7, done} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL %s idle: got busy=%b phase=%0d strobes=%b, want busy=0 phase=0 strobes=0000",
                 tag, busy, phase, {clock_3, clock_5, clock_7, done});
      end
      tests_run++;
      if (eip !== m_eip || ebp !== m_ebp || esp !== m_esp || illegal_sel !== m_ill) begin
        tests_failed++;
        $display("FAIL %s idle regs: got eip=%h ebp=%h esp=%h ill=%b, want %h %h %h %b",
                 tag, eip, ebp, esp, illegal_sel, m_eip, m_ebp, m_esp, m_ill);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    write_sel_1 = 4'd0;
    write_sel_2 = 4'd0;
    write_sel_3 = 4'd0;
    instr_len = 4'd0;
    registor_input = 32'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    tests_run++;
    if (eip !== 32'h0 || ebp !== 32'h100 || esp !== 32'h100 || illegal_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset regs: got eip=%h ebp=%h esp=%h ill=%b, want 0 100 100 0", eip, ebp, esp, illegal_sel);
    end
    idle_cycles(3, "reset");
  endtask

  task automatic test_push_copy();
    run_frame(4'd1, 4'd3, 4'd0, 4'd2, 1'b0, 32'd0, "push_copy");
    idle_cycles(1, "push_copy");
    tests_run++;
    if (eip !== 32'h2 || esp !== 32'hFC || ebp !== 32'hFC) begin
      tests_failed++;
      $display("FAIL push_copy final: got eip=%h esp=%h ebp=%h, want 2 fc fc", eip, esp, ebp);
    end
  endtask

  task automatic test_jump();
    run_frame(4'd0, 4'd0, 4'd2, 4'd5, 1'b1, 32'h0000_1234, "jump");
    idle_cycles(1, "jump");
    tests_run++;
    if (eip !== 32'h0000_1234) begin
      tests_failed++;
      $display("FAIL jump eip: got %h, want 00001234", eip);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eip0;
    eip0 = m_eip;
    run_frame(4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 32'd0, "b2b0");
    run_frame(4'd2, 4'd0, 4'd0, 4'd5, 1'b0, 32'd0, "b2b1");
    run_frame(4'd1, 4'd4, 4'd0, 4'd7, 1'b0, 32'd0, "b2b2");
    idle_cycles(1, "b2b");
    tests_run++;
    if (eip !== eip0 + 32'd15) begin
      tests_failed++;
      $display("FAIL b2b eip: got %h, want %h", eip, eip0 + 32'd15);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    apply_reset();
    start = 1'b1;
    write_sel_1 = 4'd1;
    write_sel_2 = 4'd1;
    write_sel_3 = 4'd2;
    instr_len = 4'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      start = 1'b0;
      d = $urandom;
      registor_input = d;
      if (k == 4) model_slot1(4'd1, d);
    end
    tests_run++;
    if (phase !== 3'd5 || esp !== m_esp || clock_5 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset pre: got phase=%0d esp=%h c5=%b, want 5 %h 1", phase, esp, clock_5, m_esp);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    tests_run++;
    if (eip !== 32'h0 || ebp !== 32'h100 || esp !== 32'h100 || busy !== 1'b0 || phase !== 3'd0) begin
      tests_failed++;
      $display("FAIL midreset post: got eip=%h ebp=%h esp=%h busy=%b phase=%0d, want 0 100 100 0 0",
               eip, ebp, esp, busy, phase);
    end
    idle_cycles(4, "midreset");
  endtask

  task automatic test_illegal();
    apply_reset();
    run_frame(4'd7, 4'd0, 4'd1, 4'd3, 1'b0, 32'd0, "illegal");
    idle_cycles(1, "illegal");
    tests_run++;
    if (illegal_sel !== 1'b1 || esp !== 32'h100 || ebp !== 32'h100 || eip !== 32'h0) begin
      tests_failed++;
      $display("FAIL illegal final: got ill=%b esp=%h ebp=%h eip=%h, want 1 100 100 0", illegal_sel, esp, ebp, eip);
    end
    run_frame(4'd2, 4'd0, 4'd0, 4'd1, 1'b0, 32'd0, "illegal_sticky");
    idle_cycles(1, "illegal_sticky");
    apply_reset();
    tests_run++;
    if (illegal_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal clear: got %b, want 0", illegal_sel);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int f = 0; f < 24; f++) begin
      run_frame(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 1'b0, 32'd0, "random");
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 2)), "random");
    end
    idle_cycles(1, "random_end");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_push_copy();
    test_jump();
    test_back_to_back();
    test_reset_mid_frame();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/registor_writeback.md
Name: registor_writeback

Overview:
- Write-side counterpart of the phase-based register read selector.
- Owns the eip/ebp/esp architectural registers and sequences one instruction through an 8-phase frame.
- Drives the phase strobes clock_3/clock_5/clock_7 that the read selector consumes.
- Commits registor_input, or a derived value, into the target register chosen by one write-select code per phase slot.

Parameters:
- WIDTH, 32: register and data width.
- EIP_RESET, 32'h0000_0000: eip value after reset.
- ESP_RESET, 32'h0000_0100: esp and ebp value after reset.
- STACK_STEP, 4: esp adjustment for push/pop codes.
- STACK_LIMIT, 32'h0000_0000: lowest legal esp; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to run one instruction frame.
- write_sel_1  in  4  slot-1 write code; latched on start accept.
- write_sel_2  in  4  slot-2 write code; latched on start accept.
- write_sel_3  in  4  slot-3 write code; latched on start accept.
- instr_len  in  4  eip increment in bytes; latched on start accept.
- registor_input  in  WIDTH  write data (ALU/memory result).
- eip  out  WIDTH  instruction pointer.
- ebp  out  WIDTH  base pointer.
- esp  out  WIDTH  stack pointer.
- phase  out  3  current phase 0..7; 0 when idle.
- clock_3  out  1  high during phase 3 while busy.
- clock_5  out  1  high during phase 5 while busy.
- clock_7  out  1  high during phase 7 while busy.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse during phase 7.
- illegal_sel  out  1  sticky flag: an undefined code was latched.

Behaviour:
- Reset (synchronous, any state, including mid-frame):
  - eip=EIP_RESET, ebp=esp=ESP_RESET.
  - phase=0; busy, done, clock_3/5/7 and illegal_sel all 0.
  - Latched selects cleared to 0. Pending writes are discarded.
- FSM states: IDLE, RUN.
  - IDLE with start=1 at edge T: latch write_sel_1/2/3 and instr_len; enter RUN with phase=0 at T+1.
  - RUN: phase increments by 1 each cycle.
  - From phase 7 with start=0: go to IDLE. With start=1: relatch and go directly to phase 0 (back-to-back, no idle cycle).
  - start while in phases 0..6: ignored.
- Strobes are registered decodes of phase, gated by busy. done equals clock_7.
- Commit points (register updates take effect at the edge that ends the phase):
  - Slot 1 ends phase 4.
  - Slot 2 ends phase 6.
  - Slot 3 ends phase 7.
- Slot-1 codes:
  - 0: none.
  - 1: esp <= esp - STACK_STEP.
  - 2: esp <= esp + STACK_STEP.
  - 3: esp <= registor_input.
  - 4: ebp <= registor_input.
- Slot-2 codes:
  - 0: none.
  - 1: ebp <= registor_input.
  - 2: esp <= registor_input.
  - 3: ebp <= esp.
  - 4: esp <= ebp.
- Slot-3 codes:
  - 0: eip <= eip + zero-extended instr_len.
  - 2: eip <= registor_input (jump/ret).
  - 1: eip <= eip (halt-in-place).
- Any other code in any slot: no write. Slot 3 treats it as code 0. Sets illegal_sel at the commit edge; illegal_sel clears only on reset.
- Arithmetic is modulo 2^WIDTH: esp wraps on push below 0 or pop above max, with no flag unless the optional feature is enabled.
- Exactly one register write per slot, so no same-edge conflicts exist.
- Slot-2 codes 3/4 read the esp/ebp values produced by slot 1.

Optional Feature:
- Macro: REGISTOR_STACK_GUARD_EN.
- Defined:
  - Slot-1 code 1 whose result would be < STACK_LIMIT, or would wrap below 0, is suppressed: esp unchanged.
  - Slot-1 code 2 that would wrap past 2^WIDTH-1 is suppressed.
  - Either case raises an extra output stack_fault (1 bit), sticky until reset.
- Undefined:
  - stack_fault port is absent.
  - Push/pop always wrap modulo 2^WIDTH.

Test Plan:
- Reset, then idle 3 cycles -> eip=0, esp=ebp=0x100, phase=0, all strobes 0, busy=0.
- start with sel1=1, sel2=3, sel3=0, instr_len=2 -> clock_3 high 4 cycles after start edge; esp=0xFC after phase 4; ebp=0xFC after phase 6; eip=2 after phase 7; done high one cycle.
- start with sel3=2, registor_input=0x0000_1234 at phase 7 -> eip=0x1234 at the edge ending phase 7; busy drops the next cycle.
- start held high continuously -> phase sequence 0..7,0..7 with no gap; done pulses every 8 cycles; eip advances by instr_len each frame.
- Assert reset during phase 5 after slot-1 push -> all outputs return to reset values; slot-2 and slot-3 writes do not occur.
- sel1=7 -> no register change, illegal_sel=1 after phase 4 and persists. With REGISTOR_STACK_GUARD_EN, STACK_LIMIT=0x100, sel1=1 -> esp stays 0x100 and stack_fault=1.
